alu_arb_ctrl: RTL and testbench
===============================

Name: alu_arb_ctrl

Overview:
- Sequences and shares the 4-bit ALU core (op-selected add/sub/not/and/or/xor/compare/equal) between two requesters.
- Arbitrates, latches operands, drives the ALU operand/op inputs and waits a fixed settle latency.
- Captures the 4-bit result and returns it over a valid/ready response channel.
- Holds the last result in a display register that feeds the 7-segment decoder.

Parameters:
- ALU_LAT, 1, number of EXEC cycles the ALU inputs are held before the result is sampled; legal range 1..15.
- DW, 4, operand/result width; must match the ALU core.
- OPW, 3, op-select width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 accepted this cycle.
- req0_a, req0_b  input  DW  requester 0 operands.
- req0_op  input  OPW  requester 0 op code.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1.
- alu_a, alu_b  output  DW  operands to the ALU core.
- alu_op  output  OPW  op select to the ALU core.
- alu_res  input  DW  ALU core result (combinational).
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer takes the response.
- rsp_id  output  1  requester index the response belongs to.
- rsp_data  output  DW  captured result.
- disp_val  output  DW  last captured result, to the 7-segment decoder.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: rsp_valid, rsp_id, rsp_data, disp_val, alu_a, alu_b, alu_op and busy are 0; req*_ready is 0; state IDLE; last_grant=1, so requester 0 wins the first tie.
- The FSM has three states: IDLE, EXEC and RESP.
- IDLE, arbitration:
  - req*_ready is combinational and asserted only in IDLE, for the granted requester only.
  - Exactly one ready is high when any valid is high.
- IDLE, handshake:
  - The handshake completes on the edge where valid && ready.
  - On that edge: latch a/b/op into alu_a/alu_b/alu_op; set rsp_id to the granted index; load cnt=ALU_LAT; go to EXEC.
- EXEC:
  - alu_a/b/op are held stable.
  - cnt decrements each cycle.
  - On the edge where cnt==1: rsp_data<=alu_res, disp_val<=alu_res; go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are stable until accepted.
  - On the edge with rsp_ready=1: go to IDLE, rsp_valid drops next cycle.
  - There is no new accept in that same cycle: ready is low outside IDLE, so back-to-back throughput is one op per ALU_LAT+2 cycles.
- Latency: a handshake in cycle T gives rsp_valid=1 in cycle T+ALU_LAT+1.
- Valid held low in IDLE: no state change; alu_* hold the previous values.
- A requester may drop valid before being granted; nothing is latched.
- rsp_ready asserted outside RESP is ignored.
- Result width: alu_res is captured unmodified; overflow/carry is dropped by the core and is not tracked here.
- Reset mid-operation (EXEC or RESP): the transaction is discarded, the FSM returns to IDLE and all outputs take their reset values. disp_val is also cleared.

Optional Feature:
- Macro: ALU_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On simultaneous valids, grant the requester that is not last_grant.
  - last_grant updates on each completed request handshake.
- Undefined: fixed priority; requester 0 always wins on a tie.
  - last_grant is not implemented.
  - Requester 1 is granted only when req0_valid=0.

Decomposition:
- Package alu_ctrl_pkg holds:
  - state enum {IDLE, EXEC, RESP};
  - op code constants OP_ADD=3'b000, OP_SUB=001, OP_NOT=010, OP_AND=011, OP_OR=100, OP_XOR=101, OP_CMP=110, OP_EQ=111;
  - default widths DW=4, OPW=3.
- One natural sub-module: rr_arb2.
  - Two-input arbiter with grant vector and last_grant register.
  - The ALU_ARB_RR_EN switch lives inside it.
- Counter and FSM stay in the top module.

Test Plan:
- Single op: req0 a=3, b=4, op=ADD, ALU_LAT=1, rsp_ready=1 -> req0_ready in cycle T, rsp_valid in T+2 with rsp_data=7, rsp_id=0, disp_val=7.
- Wrap: req1 a=9, b=9, op=ADD -> rsp_data=2 (4-bit wrap), rsp_id=1.
- Contention with RR: both valid continuously for 4 ops -> grants 0,1,0,1. Without macro -> grants 0,0,0,0 and req1_ready never high.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable, req*_ready low, busy=1. Releasing it returns to IDLE the next cycle.
- Latency sweep: ALU_LAT=3 -> alu_a/b/op stable for 3 cycles after accept, rsp_valid at T+4.
- Reset in EXEC: rst pulsed asynchronously mid-cycle -> immediately rsp_valid=0, disp_val=0, busy=0. The first post-reset tie is granted to req0.

Source files
------------

// File: rtl/alu_arb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_pkg
//  Description : Shared types and constants for the ALU arbiter/sequencer.
//                Holds the controller state encoding, the ALU op codes and
//                the default operand/op widths.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_ctrl_pkg;

    localparam int DW  = 4;
    localparam int OPW = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_CMP = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

endpackage
`default_nettype wire

// File: rtl/alu_arb_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arb_ctrl_if
//  Description : Bundle of the two request channels, the ALU core operand /
//                result lines, the response channel and status outputs.
//                slave  : view of the controller (alu_arb_ctrl)
//                master : view of the surrounding system (requesters, ALU
//                         core, response consumer, display)
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_arb_ctrl_if #(
    parameter int DW  = 4,
    parameter int OPW = 3
);
    logic           req0_valid;
    logic           req0_ready;
    logic [DW-1:0]  req0_a;
    logic [DW-1:0]  req0_b;
    logic [OPW-1:0] req0_op;

    logic           req1_valid;
    logic           req1_ready;
    logic [DW-1:0]  req1_a;
    logic [DW-1:0]  req1_b;
    logic [OPW-1:0] req1_op;

    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  alu_res;

    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [DW-1:0]  rsp_data;
    logic [DW-1:0]  disp_val;
    logic           busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_res, rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_op,
        output rsp_valid, rsp_id, rsp_data, disp_val, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_res, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_id, rsp_data, disp_val, busy
    );

endinterface
`default_nettype wire

// File: rtl/alu_arb_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-input arbiter producing a one-hot grant vector.
//                ALU_ARB_RR_EN defined   : round robin; on a tie the input
//                                          that did not win last is granted.
//                ALU_ARB_RR_EN undefined : fixed priority, input 0 wins.
//  Ports       : clk, rst   - clock, asynchronous active-high reset
//                req_i      - request vector {req1, req0}
//                update_i   - a grant was consumed this cycle
//                grant_o    - one-hot grant, zero when no request
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] grant_o
);

`ifdef ALU_ARB_RR_EN
    // Reset to 1 so that requester 0 takes the first tie.
    logic last_grant_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else if (update_i) begin
            last_grant_q <= grant_o[1];
        end
    end

    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = last_grant_q ? 2'b01 : 2'b10;
        end
    end
`else
    // Priority mode carries no history, so clock/reset/update are not needed.
    logic w_unused;
    assign w_unused = clk ^ rst ^ update_i;

    assign grant_o = {req_i[1] & ~req_i[0], req_i[0]};
`endif

endmodule
`default_nettype wire

// File: rtl/alu_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arb_ctrl
//  Description : Shares one combinational 4-bit ALU core between two
//                requesters. Arbitrates in IDLE, latches the winner's
//                operands onto the ALU inputs, holds them for ALU_LAT cycles
//                (EXEC), captures the result and presents it on a
//                valid/ready response channel (RESP). The last captured
//                result is also kept for the 7-segment display.
//                Optional macro ALU_ARB_RR_EN selects round-robin instead of
//                fixed-priority arbitration (inside rr_arb2).
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - alu_arb_ctrl_if.slave (requests, ALU, response,
//                       display value, busy)
//  Parameters  : ALU_LAT (1..15), DW (must match ALU core), OPW
//  Revision    : 1.0  initial release
// ============================================================================
module alu_arb_ctrl #(
    parameter int ALU_LAT = 1,
    parameter int DW      = alu_ctrl_pkg::DW,
    parameter int OPW     = alu_ctrl_pkg::OPW
) (
    input  logic          clk,
    input  logic          rst,
    alu_arb_ctrl_if.slave bus
);
    import alu_ctrl_pkg::*;

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_EXEC = ST_EXEC;
    localparam logic [1:0] S_RESP = ST_RESP;

    localparam int          CW    = 4;
    localparam logic [CW-1:0] C_LAT = CW'(ALU_LAT);

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]  a_q, a_d, b_q, b_d;
    logic [OPW-1:0] op_q, op_d;
    logic           id_q, id_d;
    logic [DW-1:0]  data_q, data_d;
    logic [DW-1:0]  disp_q, disp_d;

    logic [1:0]     w_grant;
    logic           w_idle;
    logic           w_hs;

    assign w_idle = (state_q == S_IDLE);
    // The arbiter always grants someone when any valid is high, so a
    // non-zero grant in IDLE is a completed handshake.
    assign w_hs   = w_idle && (|w_grant);

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    ({bus.req1_valid, bus.req0_valid}),
        .update_i (w_hs),
        .grant_o  (w_grant)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        id_d    = id_q;
        data_d  = data_q;
        disp_d  = disp_q;
        case (state_q)
            S_IDLE: begin
                if (w_hs) begin
                    state_d = S_EXEC;
                    cnt_d   = C_LAT;
                    id_d    = w_grant[1];
                    if (w_grant[1]) begin
                        a_d  = bus.req1_a;
                        b_d  = bus.req1_b;
                        op_d = bus.req1_op;
                    end else begin
                        a_d  = bus.req0_a;
                        b_d  = bus.req0_b;
                        op_d = bus.req0_op;
                    end
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q - CW'(1);
                // Last settle cycle: ALU output is stable, sample it.
                if (cnt_q == CW'(1)) begin
                    data_d  = bus.alu_res;
                    disp_d  = bus.alu_res;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            id_q    <= 1'b0;
            data_q  <= '0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
            data_q  <= data_d;
            disp_q  <= disp_d;
        end
    end

    assign bus.req0_ready = w_idle & w_grant[0];
    assign bus.req1_ready = w_idle & w_grant[1];
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_op     = op_q;
    assign bus.rsp_valid  = (state_q == S_RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data   = data_q;
    assign bus.disp_val   = disp_q;
    assign bus.busy       = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_alu_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arb_ctrl
//  Description : Self-checking bench for alu_arb_ctrl. Two instances share
//                one stimulus stream: ALU_LAT=1 (index 0) and ALU_LAT=3
//                (index 1). Each is checked every cycle against a
//                transaction-level model (accept time, result, release).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_arb_ctrl;
    import alu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       v0 = 1'b0, v1 = 1'b0, rr = 1'b0;
    logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [2:0] op0 = '0, op1 = '0;

    function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_NOT:  return ~a;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_CMP:  return (a > b) ? 4'd1 : 4'd0;
            default: return (a == b) ? 4'd1 : 4'd0;
        endcase
    endfunction

    alu_arb_ctrl_if #(.DW(4), .OPW(3)) bus_l1 ();
    alu_arb_ctrl_if #(.DW(4), .OPW(3)) bus_l3 ();

    assign bus_l1.req0_valid = v0;  assign bus_l3.req0_valid = v0;
    assign bus_l1.req0_a     = a0;  assign bus_l3.req0_a     = a0;
    assign bus_l1.req0_b     = b0;  assign bus_l3.req0_b     = b0;
    assign bus_l1.req0_op    = op0; assign bus_l3.req0_op    = op0;
    assign bus_l1.req1_valid = v1;  assign bus_l3.req1_valid = v1;
    assign bus_l1.req1_a     = a1;  assign bus_l3.req1_a     = a1;
    assign bus_l1.req1_b     = b1;  assign bus_l3.req1_b     = b1;
    assign bus_l1.req1_op    = op1; assign bus_l3.req1_op    = op1;
    assign bus_l1.rsp_ready  = rr;  assign bus_l3.rsp_ready  = rr;
    assign bus_l1.alu_res = alu_fn(bus_l1.alu_a, bus_l1.alu_b, bus_l1.alu_op);
    assign bus_l3.alu_res = alu_fn(bus_l3.alu_a, bus_l3.alu_b, bus_l3.alu_op);

    alu_arb_ctrl #(.ALU_LAT(1), .DW(4), .OPW(3)) dut_l1 (.clk(clk), .rst(rst), .bus(bus_l1));
    alu_arb_ctrl #(.ALU_LAT(3), .DW(4), .OPW(3)) dut_l3 (.clk(clk), .rst(rst), .bus(bus_l3));

    // Observation arrays, index 0 = ALU_LAT 1, index 1 = ALU_LAT 3
    logic       o_r0 [2], o_r1 [2], o_rv [2], o_id [2], o_busy [2];
    logic [3:0] o_a [2], o_b [2], o_data [2], o_disp [2];
    logic [2:0] o_op [2];
    assign o_r0[0] = bus_l1.req0_ready;  assign o_r0[1] = bus_l3.req0_ready;
    assign o_r1[0] = bus_l1.req1_ready;  assign o_r1[1] = bus_l3.req1_ready;
    assign o_rv[0] = bus_l1.rsp_valid;   assign o_rv[1] = bus_l3.rsp_valid;
    assign o_id[0] = bus_l1.rsp_id;      assign o_id[1] = bus_l3.rsp_id;
    assign o_busy[0] = bus_l1.busy;      assign o_busy[1] = bus_l3.busy;
    assign o_a[0] = bus_l1.alu_a;        assign o_a[1] = bus_l3.alu_a;
    assign o_b[0] = bus_l1.alu_b;        assign o_b[1] = bus_l3.alu_b;
    assign o_op[0] = bus_l1.alu_op;      assign o_op[1] = bus_l3.alu_op;
    assign o_data[0] = bus_l1.rsp_data;  assign o_data[1] = bus_l3.rsp_data;
    assign o_disp[0] = bus_l1.disp_val;  assign o_disp[1] = bus_l3.disp_val;

    // Transaction-level reference model
    int         lat [2] = '{1, 3};
    bit         m_pend [2];
    int         m_acc [2];
    logic [3:0] m_res [2], m_disp [2], m_a [2], m_b [2];
    logic [2:0] m_op [2];
    logic       m_id [2], m_last [2], prev_rv [2];
    int         rise_lat [2];
    int         gq0 [$], gq1 [$];
    int         cyc = 0;
    int         total = 0, bad = 0;

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d cyc=%0d obs=%0h exp=%0h", tag, k, cyc, obs, exp);
        end
    endtask

    function automatic int grant(input logic va, input logic vb, input logic last);
`ifdef ALU_ARB_RR_EN
        if (va && vb) return last ? 0 : 1;
`endif
        if (va) return 0;
        if (vb) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 1'b0; m_acc[k] = 0; m_res[k] = '0; m_disp[k] = '0;
            m_a[k] = '0; m_b[k] = '0; m_op[k] = '0; m_id[k] = 1'b0;
            m_last[k] = 1'b1; prev_rv[k] = 1'b0;
        end
    endtask

    task automatic check_and_update(input int k);
        bit         resp;
        int         g;
        logic [3:0] ed;
        resp = m_pend[k] && (cyc >= m_acc[k] + lat[k] + 1);
        g    = m_pend[k] ? -1 : grant(v0, v1, m_last[k]);
        ed   = resp ? m_res[k] : m_disp[k];
        chk("req0_ready", k, o_r0[k], g == 0);
        chk("req1_ready", k, o_r1[k], g == 1);
        chk("busy", k, o_busy[k], m_pend[k]);
        chk("rsp_valid", k, o_rv[k], resp);
        chk("rsp_data", k, o_data[k], ed);
        chk("disp_val", k, o_disp[k], ed);
        chk("rsp_id", k, o_id[k], m_id[k]);
        chk("alu_a", k, o_a[k], m_a[k]);
        chk("alu_b", k, o_b[k], m_b[k]);
        chk("alu_op", k, o_op[k], m_op[k]);
        if (o_rv[k] && !prev_rv[k]) rise_lat[k] = cyc - m_acc[k];
        prev_rv[k] = o_rv[k];
        if (g >= 0) begin
            m_pend[k] = 1'b1; m_acc[k] = cyc; m_id[k] = (g == 1);
            m_a[k]  = (g == 1) ? a1 : a0;
            m_b[k]  = (g == 1) ? b1 : b0;
            m_op[k] = (g == 1) ? op1 : op0;
            m_res[k] = alu_fn(m_a[k], m_b[k], m_op[k]);
            m_last[k] = (g == 1);
            if (k == 0) gq0.push_back(g); else gq1.push_back(g);
        end else if (resp && rr) begin
            m_pend[k] = 1'b0;
            m_disp[k] = m_res[k];
        end
    endtask

    task automatic step(input logic iv0, input logic [3:0] ia0, input logic [3:0] ib0,
                        input logic [2:0] iop0, input logic iv1, input logic [3:0] ia1,
                        input logic [3:0] ib1, input logic [2:0] iop1, input logic irr);
        @(negedge clk);
        v0 = iv0; a0 = ia0; b0 = ib0; op0 = iop0;
        v1 = iv1; a1 = ia1; b1 = ib1; op1 = iop1; rr = irr;
        #1;
        for (int k = 0; k < 2; k++) check_and_update(k);
        cyc++;
    endtask

    task automatic idle(input int n, input logic irr);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, irr);
    endtask

    task automatic async_reset();
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_rsp_valid", k, o_rv[k], 0);
            chk("rst_busy", k, o_busy[k], 0);
            chk("rst_disp", k, o_disp[k], 0);
            chk("rst_alu_a", k, o_a[k], 0);
            chk("rst_rsp_data", k, o_data[k], 0);
        end
        #1 rst = 1'b0;
        model_reset();
        cyc++;
    endtask

    int exp_g [4];

    initial begin
        model_reset();
        rise_lat[0] = 0; rise_lat[1] = 0;
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_rsp_valid", k, o_rv[k], 0);
            chk("reset_busy", k, o_busy[k], 0);
            chk("reset_disp", k, o_disp[k], 0);
            chk("reset_rsp_id", k, o_id[k], 0);
            chk("reset_ready", k, {o_r0[k], o_r1[k]}, 0);
        end
        rst = 1'b0;

        // Single op: 3 + 4
        step(1, 3, 4, OP_ADD, 0, 0, 0, 0, 1);
        idle(1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("single_rsp_valid", 0, o_rv[0], 1);
        chk("single_rsp_data", 0, o_data[0], 7);
        chk("single_rsp_id", 0, o_id[0], 0);
        idle(3, 1);
        for (int k = 0; k < 2; k++) chk("single_disp", k, o_disp[k], 7);

        // 4-bit wrap on requester 1
        step(0, 0, 0, 0, 1, 9, 9, OP_ADD, 1);
        idle(5, 1);
        for (int k = 0; k < 2; k++) begin
            chk("wrap_disp", k, o_disp[k], 2);
            chk("wrap_rsp_id", k, o_id[k], 1);
        end

        // Backpressure: consumer stalls, requester 1 keeps asking
        step(1, 5, 2, OP_SUB, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 1, 1, OP_OR, 0);
        for (int k = 0; k < 2; k++) begin
            chk("bp_rsp_valid", k, o_rv[k], 1);
            chk("bp_rsp_data", k, o_data[k], 3);
            chk("bp_busy", k, o_busy[k], 1);
            chk("bp_req1_ready", k, o_r1[k], 0);
        end
        chk("latency", 0, rise_lat[0], 2);
        chk("latency", 1, rise_lat[1], 4);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 2; k++) chk("bp_release_busy", k, o_busy[k], 0);

        // Reset while in EXEC
        step(1, 6, 1, OP_ADD, 0, 0, 0, 0, 1);
        async_reset();

        // Contention straight after reset
        gq0.delete(); gq1.delete();
        for (int i = 0; i < 24; i++)
            step(1, 4'($urandom), 4'($urandom), 3'($urandom), 1, 4'($urandom),
                 4'($urandom), 3'($urandom), 1);
`ifdef ALU_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        chk("contention_count", 0, gq0.size() >= 4, 1);
        chk("contention_count", 1, gq1.size() >= 4, 1);
        for (int i = 0; i < 4; i++) begin
            if (gq0.size() > i) chk("contention_grant", 0, gq0[i], exp_g[i]);
            if (gq1.size() > i) chk("contention_grant", 1, gq1[i], exp_g[i]);
        end

        // Randomized traffic with random backpressure and valid drops
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 6, 4'($urandom), 4'($urandom), 3'($urandom),
                 $urandom_range(0, 9) < 6, 4'($urandom), 4'($urandom), 3'($urandom),
                 $urandom_range(0, 1) == 1);
        idle(10, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
